// File: rtl/traffic_light_rr.sv
`default_nettype none
// ============================================================================
// traffic_light_rr : N-way round-robin traffic light controller with flash mode
// rev 1.0
// ============================================================================
module traffic_light_rr #(
  parameter int N_WAYS       = 2,
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 20,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [N_WAYS-1:0]           sensor,
  input  logic                        flash,
  output logic [3*N_WAYS-1:0]         lights,
  output logic [$clog2(N_WAYS)-1:0]   active_way,
  output logic [1:0]                  phase
);

  localparam int AW_W = $clog2(N_WAYS);

  localparam logic [1:0] c_GREEN   = 2'b00;
  localparam logic [1:0] c_YELLOW  = 2'b01;
  localparam logic [1:0] c_ALL_RED = 2'b10;
  localparam logic [1:0] c_FLASH   = 2'b11;

  localparam logic [CNT_W-1:0] c_MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] c_MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] c_YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] c_AR_LAST  = CNT_W'(ALL_RED_TIME - 1);

  localparam logic [3*N_WAYS-1:0] c_LIGHTS_RST = {{(N_WAYS-1){3'b100}}, 3'b001};

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AW_W-1:0]     active_q, active_d;
  logic [AW_W-1:0]     next_q, next_d;
  logic [N_WAYS-1:0]   pending_q, pending_d;
  logic                fphase_q, fphase_d;
  logic [3*N_WAYS-1:0] lights_q, lights_d;

  logic [N_WAYS-1:0]   w_active_oh;
  logic [N_WAYS-1:0]   w_entry_oh;
  logic                w_other;
  logic [AW_W-1:0]     w_rr_pick;

  assign w_active_oh = N_WAYS'(1) << active_q;
  assign w_entry_oh  = N_WAYS'(1) << active_d;
  assign w_other     = |(pending_q & ~w_active_oh);

  // Scan from the far end back toward active+1 so the nearest pending way wins.
  always_comb begin
    int idx;
    w_rr_pick = '0;
    idx       = 0;
    for (int k = N_WAYS - 1; k >= 1; k--) begin
      idx = (int'(active_q) + k) % N_WAYS;
      if (pending_q[AW_W'(idx)]) w_rr_pick = AW_W'(idx);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    next_d   = next_q;
    fphase_d = fphase_q;
    if (flash) begin
      if (state_q != c_FLASH) begin
        state_d  = c_FLASH;
        cnt_d    = '0;
        fphase_d = 1'b1;
      end else if (tick) begin
        fphase_d = ~fphase_q;
      end
    end else begin
      case (state_q)
        c_GREEN: begin
          if (tick) begin
            if (w_other && ((cnt_q >= c_MIN_LAST && !sensor[active_q]) ||
                            cnt_q >= c_MAX_LAST)) begin
              state_d = c_YELLOW;
              cnt_d   = '0;
              next_d  = w_rr_pick;
            end else if (active_q != '0 && pending_q == '0 &&
                         cnt_q >= c_MIN_LAST) begin
              state_d = c_YELLOW;
              cnt_d   = '0;
              next_d  = '0;
            end else if (cnt_q < c_MAX_LAST) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        c_YELLOW: begin
          if (tick) begin
            if (cnt_q >= c_YEL_LAST) begin
              state_d = c_ALL_RED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        c_ALL_RED: begin
          if (tick) begin
            if (cnt_q >= c_AR_LAST) begin
              state_d  = c_GREEN;
              cnt_d    = '0;
              active_d = next_q;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          // Leaving flash always clears through all-red back to the main road.
          state_d = c_ALL_RED;
          cnt_d   = '0;
          next_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q | (sensor & ~((state_q == c_GREEN) ? w_active_oh : '0));
    if (state_d == c_GREEN && state_q != c_GREEN) pending_d = pending_d & ~w_entry_oh;
  end

  // Lights are decoded from the next state so they line up with phase/active_way.
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      case (state_d)
        c_GREEN:   lights_d[3*i +: 3] = (AW_W'(i) == active_d) ? 3'b001 : 3'b100;
        c_YELLOW:  lights_d[3*i +: 3] = (AW_W'(i) == active_d) ? 3'b010 : 3'b100;
        c_ALL_RED: lights_d[3*i +: 3] = 3'b100;
        default:   lights_d[3*i +: 3] = fphase_d ? 3'b010 : 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_GREEN;
      cnt_q     <= '0;
      active_q  <= '0;
      next_q    <= '0;
      pending_q <= '0;
      fphase_q  <= 1'b0;
      lights_q  <= c_LIGHTS_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      next_q    <= next_d;
      pending_q <= pending_d;
      fphase_q  <= fphase_d;
      lights_q  <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign active_way = active_q;
  assign phase      = state_q;

endmodule
`default_nettype wire

// File: doc/traffic_light_rr.md
TRAFFIC_LIGHT_RR -- requirements
Module: traffic_light_rr

Interface
REQ-001 SHALL provide parameter N_WAYS, default 2, number of approaches (legal 2..8); approach 0 is the main road.
REQ-002 SHALL provide parameter MIN_GREEN, default 5, minimum green duration in ticks (>=1).
REQ-003 SHALL provide parameter MAX_GREEN, default 20, maximum green duration in ticks while other demand exists (>=MIN_GREEN).
REQ-004 SHALL provide parameter YELLOW_TIME, default 3, yellow duration in ticks (>=1).
REQ-005 SHALL provide parameter ALL_RED_TIME, default 1, all-red clearance duration in ticks (>=1).
REQ-006 SHALL provide parameter CNT_W, default 8, timer width; it must hold MAX_GREEN-1.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 tick  input  1  time-base enable; timers advance only on cycles with tick=1.
REQ-010 sensor  input  N_WAYS  per-approach vehicle detect, level-sensitive, bit i = approach i.
REQ-011 flash  input  1  maintenance flash-mode request, level-sensitive.
REQ-012 lights  output  3*N_WAYS  registered; lights[3i+2:3i] = {R,Y,G} of approach i.
REQ-013 active_way  output  $clog2(N_WAYS)  approach currently owning green/yellow.
REQ-014 phase  output  2  00 GREEN, 01 YELLOW, 10 ALL_RED, 11 FLASH.

Function
REQ-015 SHALL implement the FSM states GREEN, YELLOW, ALL_RED and FLASH, with one tick counter cleared on every state entry.
REQ-016 SHALL drive lights: GREEN -> active 001, others 100; YELLOW -> active 010, others 100; ALL_RED -> all 100; FLASH -> all 010 when flash_phase=1, all 000 otherwise.
REQ-017 SHALL set pending[i] on any cycle with sensor[i]=1, except approach i in GREEN, and SHALL clear pending[i] on entry to GREEN for approach i.
REQ-018 SHALL define other demand as any pending bit set for an approach other than active_way.
REQ-019 GREEN, evaluated only on tick: exit to YELLOW if counter>=MIN_GREEN-1, other demand exists and sensor[active_way]=0 (gap-out).
REQ-020 GREEN, evaluated only on tick: exit to YELLOW if counter>=MAX_GREEN-1 and other demand exists, regardless of the sensor (max-out).
REQ-021 GREEN with active_way!=0, no pending bits and counter>=MIN_GREEN-1 on tick: exit to YELLOW with next approach 0.
REQ-022 GREEN counter SHALL saturate at MAX_GREEN-1 and never wrap; approach 0 with no demand holds green indefinitely.
REQ-023 SHALL latch the next approach at GREEN exit: the first pending approach in round-robin order active_way+1, +2, ... mod N_WAYS, otherwise 0.
REQ-024 YELLOW SHALL last exactly YELLOW_TIME ticks, then go to ALL_RED; ALL_RED SHALL last exactly ALL_RED_TIME ticks, then go to GREEN with active_way = latched next approach.
REQ-025 flash=1 SHALL enter FLASH on the next clk edge from any state; flash_phase starts at 1 and toggles on each tick.
REQ-026 flash deasserted in FLASH SHALL go to ALL_RED for ALL_RED_TIME ticks, then GREEN on approach 0; pending bits are retained through FLASH.
REQ-027 Simultaneous tick expiry and flash=1 SHALL resolve to FLASH.
REQ-028 Two approaches never show non-red at once outside FLASH; lights SHALL change only on clk edges.

Reset
REQ-029 rst=1 SHALL take priority over flash and tick.
REQ-030 On rst=1 the block SHALL enter GREEN, with active_way=0, counter=0, pending=0, flash_phase=0, phase=00, lights = approach 0 001 and all others 100.
REQ-031 rst asserted mid-YELLOW, mid-ALL_RED or mid-FLASH SHALL give the reset state on the next edge, with no residual pending.

Verification (N_WAYS=2 unless stated, defaults otherwise, tick=1 every cycle)
REQ-032 Reset, sensor=0 for 100 cycles -> lights=100_001, active_way=0, phase=00 throughout.
REQ-033 One-cycle sensor[1] pulse at cycle 10 after reset -> approach 0 yellow 3 cycles, all-red 1 cycle, then approach 1 green (lights=001_100); after 5 more ticks with no demand it returns to approach 0 via yellow and all-red.
REQ-034 sensor[0] and sensor[1] held high -> approach 0 green lasts exactly 20 ticks (max-out), then they alternate with 20-tick greens.
REQ-035 N_WAYS=4, approach 0 green, sensor[3] and sensor[1] pulsed together -> service order 1, then 3, then 0.
REQ-036 flash=1 mid-GREEN -> next edge phase=11 and lights alternate all-010 / all-000 each tick; flash=0 -> 1 all-red tick, then approach 0 green.
REQ-037 rst pulsed during YELLOW with tick held 0 -> reset state on the next edge, and pending empty afterwards.
